// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode seven-segment driver.
// Advances one digit per scan tick, blanks all anodes for GUARD_CYCLES
// between digits, and decodes a per-frame snapshot of the digit bus into
// active-low segment, decimal-point and anode drives.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros).
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic                      frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // Counter is loaded with G-1 so the new anode lights exactly G edges
  // after the accepted tick.
  localparam logic [7:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]     snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_n_q, dp_n_d;
  logic                      frame_start_q, frame_start_d;

  logic                      accept;
  logic                      wrap;
  logic [IDX_W-1:0]          idx_inc;
  logic [3:0]                nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      lit;
  logic [NUM_DIGITS-1:0]     drive_an;
  logic [6:0]                drive_seg;
  logic                      drive_dp_n;

  // Tick acceptance, index advance and frame-wrap snapshot selection.
  always_comb begin
    accept     = tick && (state_q != ST_GUARD);
    idx_inc    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    wrap       = accept && (idx_q == IDX_LAST);
    idx_d      = accept ? idx_inc : idx_q;
    snap_dig_d = wrap ? digits   : snap_dig_q;
    snap_en_d  = wrap ? digit_en : snap_en_q;
    snap_dp_d  = wrap ? dp       : snap_dp_q;
  end

  // Per-digit view of the (next) snapshot and the anode pattern per digit.
  // The drive values are computed from the next-cycle index and snapshot so
  // that a zero-guard configuration lights the new digit on the tick edge.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib_arr[gi]  = snap_dig_d[4*gi +: 4];
    assign drive_an[gi] = !(lit && (idx_d == IDX_W'(gi)));
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero; such
  // digits sit above the most significant nonzero nibble. Digit 0 is
  // never blanked so a zero value still shows a single 0.
  logic [NUM_DIGITS:1] zero_from;
  assign zero_from[NUM_DIGITS] = 1'b1;
  assign lz_mask[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign zero_from[gi] = (nib_arr[gi] == 4'h0) && zero_from[gi+1];
    assign lz_mask[gi]   = zero_from[gi];
  end
`else
  assign lz_mask = '0;
`endif

  // Decode of the digit that will be lit next; disabled or blanked digits
  // keep their slot with everything dark.
  always_comb begin
    lit        = snap_en_d[idx_d] && !lz_mask[idx_d];
    drive_seg  = lit ? hex_to_seg(nib_arr[idx_d]) : SEG_OFF;
    drive_dp_n = lit ? !snap_dp_d[idx_d] : 1'b1;
  end

  // Scan FSM next-state and registered output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_n_d        = dp_n_q;
    frame_start_d = wrap;
    case (state_q)
      ST_WAIT, ST_DRIVE: begin
        if (tick) begin
          if (GUARD_CYCLES > 0) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
            dp_n_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            an_d    = drive_an;
            seg_d   = drive_seg;
            dp_n_d  = drive_dp_n;
          end
        end
      end
      ST_GUARD: begin
        // Ticks here are ignored; only the counter runs.
        if (cnt_q == 8'd0) begin
          state_d = ST_DRIVE;
          an_d    = drive_an;
          seg_d   = drive_seg;
          dp_n_d  = drive_dp_n;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_n_d  = 1'b1;
      end
    endcase
  end

  // Scan state, index, guard counter and output registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT;
      idx_q         <= IDX_LAST;
      cnt_q         <= 8'd0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Frame snapshot of digit data, enables and decimal points.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_dig_q <= '0;
      snap_en_q  <= '0;
      snap_dp_q  <= '0;
    end else begin
      snap_dig_q <= snap_dig_d;
      snap_en_q  <= snap_en_d;
      snap_dp_q  <= snap_dp_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: scoreboard of expected digit slots, filled
// when a tick is driven and drained when each slot's due cycle arrives.
module tb_seven_seg_scanner;

  localparam int N = 4;
  localparam int G = 4;

  logic          sys_clk;
  logic          reset_n;
  logic          tick;
  logic          tick_g0;
  logic [15:0]   digits;
  logic [3:0]    digit_en;
  logic [3:0]    dp;
  logic [3:0]    an, an_g0;
  logic [6:0]    seg, seg_g0;
  logic          dp_n, dp_n_g0;
  logic          frame_start, frame_start_g0;

  seven_seg_scanner #(.NUM_DIGITS(N), .GUARD_CYCLES(G)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .tick(tick),
    .digits(digits), .digit_en(digit_en), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
  );

  seven_seg_scanner #(.NUM_DIGITS(N), .GUARD_CYCLES(0)) dut_g0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .tick(tick_g0),
    .digits(digits), .digit_en(digit_en), .dp(dp),
    .an(an_g0), .seg(seg_g0), .dp_n(dp_n_g0), .frame_start(frame_start_g0)
  );

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int         due;
    int         digit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  int early_cnt = 0;
  bit watch_idle = 0;

  // bench model of the G=4 instance
  int         m_idx = N - 1;
  int         last_acc = -1000;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_dp = '0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("[cyc %0d] %s = %0h ok", cyc, tag, got);
    end
  endtask

  // Expected outputs for digit i given the model snapshot.
  task automatic expect_digit(input int i, output logic [3:0] a, output logic [6:0] s, output logic d);
    bit blank;
    logic [15:0] upper;
    upper = m_dig >> (4 * i);
    blank = !m_en[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0 && upper == 16'h0) blank = 1'b1;
`endif
    if (blank) begin
      a = 4'hF; s = 7'h7F; d = 1'b1;
    end else begin
      a = ~(4'b0001 << i); s = lut[upper[3:0]]; d = !m_dp[i];
    end
  endtask

  // Monitor: overlap, idle-window watch and scoreboard drain.
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if ($countones(~an) > 1 || $countones(~an_g0) > 1) overlap_cnt++;
    if (watch_idle && an !== 4'hF) early_cnt++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check($sformatf("d%0d_an", e.digit), an, e.an);
      check($sformatf("d%0d_seg", e.digit), seg, e.seg);
      check($sformatf("d%0d_dp_n", e.digit), dp_n, e.dp_n);
    end
  end

  // Drive one tick to the G=4 instance, push its expected slots, wait gap cycles.
  task automatic pulse(input int gap);
    int k;
    bit wrap;
    exp_t e;
    tick = 1'b1;
    k = cyc + 1;
    wrap = 1'b0;
    if (k > last_acc + G) begin
      last_acc = k;
      m_idx = (m_idx + 1) % N;
      if (m_idx == 0) begin
        wrap = 1'b1;
        m_dig = digits; m_en = digit_en; m_dp = dp;
      end
      e.due = k + G - 1; e.digit = m_idx; e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1;
      sb_q.push_back(e);
      e.due = k + G;
      expect_digit(m_idx, e.an, e.seg, e.dp_n);
      sb_q.push_back(e);
    end
    @(negedge sys_clk);
    tick = 1'b0;
    check("frame_start", frame_start, wrap);
    repeat (gap - 1) @(negedge sys_clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) @(negedge sys_clk);
    check("sb_drain", sb_q.size(), 0);
  endtask

  task automatic idle_window(input int n);
    early_cnt = 0;
    watch_idle = 1'b1;
    repeat (n) @(negedge sys_clk);
    watch_idle = 1'b0;
    check("no_anode_before_tick", early_cnt, 0);
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; tick_g0 = 1'b0;
    digits = 16'h1234; digit_en = 4'hF; dp = 4'h0;
    repeat (3) @(negedge sys_clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_an_g0", an_g0, 4'hF);
    reset_n = 1'b1;
    idle_window(20);

    // basic scan of 1234
    repeat (4) pulse(100);
    drain();

    // zero-guard instance: anode changes on the tick edge itself
    check("g0_before", an_g0, 4'hF);
    tick_g0 = 1'b1;
    @(negedge sys_clk);
    tick_g0 = 1'b0;
    check("g0_d0_an", an_g0, 4'b1110);
    check("g0_d0_seg", seg_g0, 7'h19);
    check("g0_frame_start", frame_start_g0, 1'b1);
    repeat (5) @(negedge sys_clk);
    tick_g0 = 1'b1;
    @(negedge sys_clk);
    tick_g0 = 1'b0;
    check("g0_d1_an", an_g0, 4'b1101);
    check("g0_d1_seg", seg_g0, 7'h30);
    check("g0_no_frame", frame_start_g0, 1'b0);

    // snapshot coherence: change digits while digit 2 is lit
    pulse(100);
    pulse(100);
    pulse(50);
    digits = 16'hABCD;
    repeat (50) @(negedge sys_clk);
    pulse(100);
    pulse(100);
    drain();

    // blanking and decimal point
    digit_en = 4'b1011; dp = 4'b0001;
    repeat (8) pulse(20);
    drain();

    // ticks 3 cycles apart: middle one dropped
    pulse(3);
    pulse(3);
    pulse(20);
    drain();

    // leading zeros
    digit_en = 4'hF; dp = 4'h0; digits = 16'h0050;
    repeat (8) pulse(20);
    digits = 16'h0000;
    repeat (8) pulse(20);
    drain();

    // reset while a digit is lit
    digits = 16'h1234;
    repeat (8) pulse(20);
    drain();
    check("pre_reset_lit", ($countones(~an) == 1), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp_n", dp_n, 1'b1);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    m_idx = N - 1;
    last_acc = -1000;
    idle_window(30);
    pulse(20);
    drain();

    check("overlap_cycles", overlap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
